// File: rtl/alu_issue_ctrl.sv
// Single-entry ALU issue controller: holds one decoded instruction, checks it
// against a register scoreboard, and presents it to the ALU once hazard-free.
module alu_issue_ctrl #(
  parameter int xlen = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // decode side
  input  logic            in_v,
  output logic            in_ok,
  input  logic [2:0]      in_sub_unit,
  input  logic [3:0]      in_sel,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_imm,
  input  logic [xlen-1:0] in_immediate,
  // register file
  output logic [4:0]      rf_rs1_idx,
  output logic [4:0]      rf_rs2_idx,
  input  logic [xlen-1:0] rf_rs1_data,
  input  logic [xlen-1:0] rf_rs2_data,
  // ALU side
  output logic            iss_v,
  output logic [2:0]      iss_sub_unit,
  output logic [3:0]      iss_sel,
  output logic [xlen-1:0] iss_rs1,
  output logic [xlen-1:0] iss_rs2,
  output logic [4:0]      iss_rd,
  output logic            iss_imm,
  output logic [xlen-1:0] iss_immediate,
  input  logic            alu_ok_i,
  // writeback / control
  input  logic            wb_v,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic [31:0]     busy_o,
  output logic [15:0]     stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WAIT_HAZ = 2'd1,
    WAIT_ALU = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]      sub_unit;
    logic [3:0]      sel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            imm;
    logic [xlen-1:0] immediate;
  } instr_t;

  // rs2 is not read when the immediate replaces it; rd is checked to keep WAW order.
  function automatic logic hazard_of(input instr_t ins, input logic [31:0] busy);
    return busy[ins.rs1] | (busy[ins.rs2] & ~ins.imm) | busy[ins.rd];
  endfunction

  state_e        state_q, state_d;
  instr_t        hold_q, hold_d;
  logic [31:0]   busy_q, busy_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  instr_t        in_instr;
  logic          held;
  logic          hazard;
  logic          fire;
  logic          accept;

  always_comb begin
    in_instr = '{sub_unit:  in_sub_unit,
                 sel:       in_sel,
                 rs1:       in_rs1,
                 rs2:       in_rs2,
                 rd:        in_rd,
                 imm:       in_imm,
                 immediate: in_immediate};
  end

  // Handshake and hazard decode; the check uses registered busy only, so a
  // writeback frees a waiting instruction one cycle later.
  always_comb begin
    held   = (state_q != EMPTY);
    hazard = held & hazard_of(hold_q, busy_q);
    iss_v  = held & ~hazard & ~flush;
    fire   = iss_v & alu_ok_i;
    in_ok  = ~flush & (~held | fire);
    accept = in_v & in_ok;
  end

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------- scoreboard, holding register, stall counter ----------------
  // NOTE: every variable assigned in a combinational block gets a default at the
  // top; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    busy_d = busy_q;
    if (wb_v && (wb_rd != 5'd0)) busy_d[wb_rd] = 1'b0;
    // Applied after the clear so an issue to the same register wins.
    if (fire && (hold_q.rd != 5'd0)) busy_d[hold_q.rd] = 1'b1;
    busy_d[0] = 1'b0;

    hold_d = hold_q;
    if (accept) hold_d = in_instr;

    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // ---------------- next-state ----------------
  // WAIT_HAZ/WAIT_ALU mirror whether the held instruction will see a hazard
  // against next cycle's busy vector.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (accept) state_d = hazard_of(in_instr, busy_d) ? WAIT_HAZ : WAIT_ALU;
      end
      WAIT_HAZ, WAIT_ALU: begin
        if (accept)    state_d = hazard_of(in_instr, busy_d) ? WAIT_HAZ : WAIT_ALU;
        else if (fire) state_d = EMPTY;
        else           state_d = hazard_of(hold_q, busy_d) ? WAIT_HAZ : WAIT_ALU;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // ---------------- outputs ----------------
  always_comb begin
    rf_rs1_idx    = hold_q.rs1;
    rf_rs2_idx    = hold_q.rs2;
    iss_sub_unit  = hold_q.sub_unit;
    iss_sel       = hold_q.sel;
    iss_rd        = hold_q.rd;
    iss_imm       = hold_q.imm;
    iss_immediate = hold_q.immediate;
    // Register-file data is only meaningful while an instruction is held.
    iss_rs1       = held ? rf_rs1_data : '0;
    iss_rs2       = held ? rf_rs2_data : '0;
    busy_o        = busy_q;
    stall_cnt     = stall_cnt_q;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: issue flow, RAW/WAW hazards, collisions,
// backpressure, flush, stall saturation and asynchronous reset.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_v;
  logic        in_ok;
  logic [2:0]  in_sub_unit;
  logic [3:0]  in_sel;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_imm;
  logic [31:0] in_immediate;
  logic [4:0]  rf_rs1_idx, rf_rs2_idx;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        iss_v;
  logic [2:0]  iss_sub_unit;
  logic [3:0]  iss_sel;
  logic [31:0] iss_rs1, iss_rs2;
  logic [4:0]  iss_rd;
  logic        iss_imm;
  logic [31:0] iss_immediate;
  logic        alu_ok_i;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_o;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.xlen(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_v(in_v), .in_ok(in_ok),
    .in_sub_unit(in_sub_unit), .in_sel(in_sel),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_immediate(in_immediate),
    .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .iss_v(iss_v), .iss_sub_unit(iss_sub_unit), .iss_sel(iss_sel),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_imm(iss_imm), .iss_immediate(iss_immediate),
    .alu_ok_i(alu_ok_i),
    .wb_v(wb_v), .wb_rd(wb_rd), .flush(flush),
    .busy_o(busy_o), .stall_cnt(stall_cnt)
  );

  // Register-file model: data tags the index so the operand path is visible.
  assign rf_rs1_data = 32'hA000_0000 | {27'd0, rf_rs1_idx};
  assign rf_rs2_data = 32'hB000_0000 | {27'd0, rf_rs2_idx};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic imm, input logic [31:0] immv,
                      input logic [2:0] sub, input logic [3:0] sel);
    in_v         = 1'b1;
    in_rd        = rd;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_imm       = imm;
    in_immediate = immv;
    in_sub_unit  = sub;
    in_sel       = sel;
  endtask

  initial begin
    rst_n = 1'b0; in_v = 1'b0; in_sub_unit = '0; in_sel = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = 1'b0; in_immediate = '0;
    alu_ok_i = 1'b1; wb_v = 1'b0; wb_rd = '0; flush = 1'b0;

    // ---- reset state ----
    #1;
    check("rst_iss_v", {31'd0, iss_v}, 32'd0);
    check("rst_busy", busy_o, 32'd0);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);
    check("rst_iss_rs1", iss_rs1, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    check("rel_in_ok", {31'd0, in_ok}, 32'd1);
    check("rel_iss_v", {31'd0, iss_v}, 32'd0);

    // ---- back-to-back independent adds to x1, x2 ----
    send(5'd1, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 4'd0);
    #1;
    check("b2b_in_ok_empty", {31'd0, in_ok}, 32'd1);
    cyc();
    send(5'd2, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 4'd0);
    #1;
    check("b2b_iss_v_1", {31'd0, iss_v}, 32'd1);
    check("b2b_iss_rd_1", {27'd0, iss_rd}, 32'd1);
    check("b2b_in_ok_fire", {31'd0, in_ok}, 32'd1);
    cyc();
    in_v = 1'b0;
    #1;
    check("b2b_iss_v_2", {31'd0, iss_v}, 32'd1);
    check("b2b_iss_rd_2", {27'd0, iss_rd}, 32'd2);
    check("b2b_busy_mid", busy_o, 32'h2);
    cyc();
    check("b2b_busy", busy_o, 32'h6);
    check("b2b_empty", {31'd0, iss_v}, 32'd0);
    wb_v = 1'b1; wb_rd = 5'd1;
    cyc();
    wb_rd = 5'd2;
    cyc();
    wb_v = 1'b0;
    #1;
    check("wb_clear", busy_o, 32'd0);

    // ---- RAW on x5 ----
    send(5'd5, 5'd1, 5'd2, 1'b0, 32'd0, 3'd1, 4'd2);
    cyc();
    send(5'd6, 5'd5, 5'd0, 1'b0, 32'd0, 3'd1, 4'd2);
    #1;
    check("raw_a_iss_v", {31'd0, iss_v}, 32'd1);
    check("raw_a_rd", {27'd0, iss_rd}, 32'd5);
    check("raw_a_rs1_data", iss_rs1, 32'hA000_0001);
    check("raw_a_rs2_data", iss_rs2, 32'hB000_0002);
    check("raw_a_rf_idx", {27'd0, rf_rs1_idx}, 32'd1);
    cyc();
    in_v = 1'b0;
    #1;
    check("raw_stall_iss_v", {31'd0, iss_v}, 32'd0);
    check("raw_busy", busy_o, 32'h20);
    check("raw_stall_0", {16'd0, stall_cnt}, 32'd0);
    cyc();
    check("raw_stall_1", {16'd0, stall_cnt}, 32'd1);
    cyc();
    wb_v = 1'b1; wb_rd = 5'd5;
    #1;
    check("raw_no_bypass", {31'd0, iss_v}, 32'd0);
    check("raw_stall_2", {16'd0, stall_cnt}, 32'd2);
    cyc();
    wb_v = 1'b0;
    #1;
    check("raw_after_wb_iss_v", {31'd0, iss_v}, 32'd1);
    check("raw_after_wb_rd", {27'd0, iss_rd}, 32'd6);
    check("raw_stall_3", {16'd0, stall_cnt}, 32'd3);
    check("raw_busy_cleared", busy_o, 32'd0);
    cyc();
    check("raw_busy_x6", busy_o, 32'h40);
    wb_v = 1'b1; wb_rd = 5'd6;
    cyc();
    wb_v = 1'b0;

    // ---- set/clear collision on x3, then WAW ----
    send(5'd3, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 4'd0);
    cyc();
    in_v = 1'b0;
    wb_v = 1'b1; wb_rd = 5'd3;
    #1;
    check("coll_iss_v", {31'd0, iss_v}, 32'd1);
    cyc();
    wb_v = 1'b0;
    #1;
    check("coll_set_wins", busy_o, 32'h8);
    send(5'd3, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 4'd0);
    cyc();
    in_v = 1'b0;
    #1;
    check("waw_blocked", {31'd0, iss_v}, 32'd0);
    wb_v = 1'b1; wb_rd = 5'd3;
    cyc();
    wb_v = 1'b0;
    #1;
    check("waw_released", {31'd0, iss_v}, 32'd1);
    check("waw_busy_clear", busy_o, 32'd0);
    cyc();
    check("waw_busy_set", busy_o, 32'h8);
    wb_v = 1'b1; wb_rd = 5'd3;
    cyc();
    wb_v = 1'b0;
    #1;
    check("waw_cleanup", busy_o, 32'd0);

    // ---- ALU backpressure, immediate operand ----
    send(5'd7, 5'd1, 5'd2, 1'b1, 32'h1234_5678, 3'd3, 4'd9);
    cyc();
    in_v = 1'b0;
    alu_ok_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_iss_v", {31'd0, iss_v}, 32'd1);
      check("bp_in_ok", {31'd0, in_ok}, 32'd0);
      check("bp_immediate", iss_immediate, 32'h1234_5678);
      check("bp_sel", {28'd0, iss_sel}, 32'd9);
      check("bp_sub", {29'd0, iss_sub_unit}, 32'd3);
      check("bp_imm", {31'd0, iss_imm}, 32'd1);
      check("bp_busy", busy_o, 32'd0);
      cyc();
    end
    alu_ok_i = 1'b1;
    #1;
    check("bp_release_iss_v", {31'd0, iss_v}, 32'd1);
    check("bp_release_in_ok", {31'd0, in_ok}, 32'd1);
    cyc();
    check("bp_busy_x7", busy_o, 32'h80);
    check("bp_empty", {31'd0, iss_v}, 32'd0);
    // rs2 = busy x7 is ignored because the immediate replaces it
    send(5'd8, 5'd0, 5'd7, 1'b1, 32'd4, 3'd0, 4'd0);
    cyc();
    in_v = 1'b0;
    #1;
    check("imm_skips_rs2", {31'd0, iss_v}, 32'd1);
    cyc();
    check("imm_busy", busy_o, 32'h180);
    wb_v = 1'b1; wb_rd = 5'd7;
    cyc();
    wb_rd = 5'd8;
    cyc();
    wb_v = 1'b0;

    // ---- flush while in WAIT_HAZ, then rd=x0 issue ----
    send(5'd9, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 4'd0);
    cyc();
    send(5'd10, 5'd9, 5'd0, 1'b0, 32'd0, 3'd0, 4'd0);
    #1;
    check("fl_g_rd", {27'd0, iss_rd}, 32'd9);
    cyc();
    in_v = 1'b0;
    #1;
    check("fl_haz_iss_v", {31'd0, iss_v}, 32'd0);
    check("fl_haz_busy", busy_o, 32'h200);
    cyc();
    flush = 1'b1;
    #1;
    check("fl_iss_v", {31'd0, iss_v}, 32'd0);
    check("fl_in_ok", {31'd0, in_ok}, 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    check("fl_after_iss_v", {31'd0, iss_v}, 32'd0);
    check("fl_after_busy", busy_o, 32'h200);
    check("fl_after_in_ok", {31'd0, in_ok}, 32'd1);
    wb_v = 1'b1; wb_rd = 5'd9;
    cyc();
    wb_v = 1'b0;
    #1;
    check("fl_wb_clear", busy_o, 32'd0);
    send(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 4'd0);
    cyc();
    in_v = 1'b0;
    #1;
    check("x0_iss_v", {31'd0, iss_v}, 32'd1);
    cyc();
    check("x0_busy", busy_o, 32'd0);

    // ---- stall-counter saturation, then reset mid-hold ----
    send(5'd11, 5'd0, 5'd0, 1'b0, 32'd0, 3'd0, 4'd0);
    cyc();
    send(5'd12, 5'd11, 5'd0, 1'b1, 32'hDEAD_BEEF, 3'd2, 4'd5);
    cyc();
    in_v = 1'b0;
    #1;
    check("sat_hold_iss_v", {31'd0, iss_v}, 32'd0);
    repeat (65540) cyc();
    check("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
    check("sat_iss_v", {31'd0, iss_v}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_iss_v", {31'd0, iss_v}, 32'd0);
    check("mid_rst_busy", busy_o, 32'd0);
    check("mid_rst_stall", {16'd0, stall_cnt}, 32'd0);
    check("mid_rst_iss_rd", {27'd0, iss_rd}, 32'd0);
    check("mid_rst_immediate", iss_immediate, 32'd0);
    check("mid_rst_iss_rs1", iss_rs1, 32'd0);
    check("mid_rst_rf_idx", {27'd0, rf_rs1_idx}, 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ok", {31'd0, in_ok}, 32'd1);
    check("post_rst_iss_v", {31'd0, iss_v}, 32'd0);
    cyc();
    check("post_rst_iss_v_2", {31'd0, iss_v}, 32'd0);
    check("post_rst_stall", {16'd0, stall_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
